// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp codes,
// mux select codes and the control FSM state encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes are also decoded by the ALU control unit.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_src, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_src, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal, state
  );

endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, addi, j),
// stalling FETCH/MEMRD/MEMWR on the memory ready handshake.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t state_q;
  state_t state_d;

  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic       pc_write;
  logic       branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low so no write enable can pulse while it is held.
  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        illegal   = !is_supported(bus.opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      alu_op     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
    end
  end

  assign bus.alu_op     = alu_op;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_src     = pc_src;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal;
  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are queued
// as stimulus is applied and checked against the DUT mid-cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_en;
    logic       illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    tests_run    = 0;
  int    tests_failed = 0;
  ctrl_t expected_q[$];

  // Expected control word for a state, written straight from the state table.
  function automatic ctrl_t spec_outputs(input logic [3:0] st, input logic mr,
                                         input logic z, input logic [5:0] op);
    ctrl_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      4'd1:  begin
        e.alu_src_b = 2'b11;
        e.illegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                      op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3:  begin e.iord = 1; e.mem_read = 1; end
      4'd4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      4'd5:  begin e.iord = 1; e.mem_write = 1; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      4'd7:  begin e.reg_dst = 1; e.reg_write = 1; end
      4'd8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      4'd9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd10: e.reg_write = 1;
      4'd11: begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t o;
    o.state      = bus.state;
    o.alu_op     = bus.alu_op;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.pc_src     = bus.pc_src;
    o.iord       = bus.iord;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.pc_en      = bus.pc_en;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  task automatic check_output(input string tag);
    ctrl_t exp;
    ctrl_t obs;
    exp = expected_q.pop_front();
    obs = observed();
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic apply_stimulus(input string tag, input logic [3:0] st,
                                input logic mr, input logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    expected_q.push_back(spec_outputs(st, mr, z, bus.opcode));
    @(negedge clk);
    check_output(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    expected_q.push_back('0);
    check_output("reset_hold");
    reset = 1'b0;

    bus.opcode = 6'b000000;
    apply_stimulus("r_fetch",  4'd0, 1, 0);
    apply_stimulus("r_decode", 4'd1, 1, 0);
    apply_stimulus("r_exec",   4'd6, 1, 0);
    apply_stimulus("r_aluwb",  4'd7, 1, 0);

    bus.opcode = 6'b100011;
    apply_stimulus("lw_fetch",   4'd0, 1, 0);
    apply_stimulus("lw_decode",  4'd1, 1, 0);
    apply_stimulus("lw_memadr",  4'd2, 1, 0);
    apply_stimulus("lw_stall1",  4'd3, 0, 0);
    apply_stimulus("lw_stall2",  4'd3, 0, 0);
    apply_stimulus("lw_memrd",   4'd3, 1, 0);
    apply_stimulus("lw_memwb",   4'd4, 1, 0);

    bus.opcode = 6'b000100;
    apply_stimulus("beq1_fetch",  4'd0, 1, 1);
    apply_stimulus("beq1_decode", 4'd1, 1, 1);
    apply_stimulus("beq1_branch", 4'd8, 1, 1);
    apply_stimulus("beq0_fetch",  4'd0, 1, 0);
    apply_stimulus("beq0_decode", 4'd1, 1, 0);
    apply_stimulus("beq0_branch", 4'd8, 1, 0);

    bus.opcode = 6'b101011;
    apply_stimulus("sw_fetch",  4'd0, 1, 0);
    apply_stimulus("sw_decode", 4'd1, 1, 0);
    apply_stimulus("sw_memadr", 4'd2, 1, 0);
    apply_stimulus("sw_stall1", 4'd5, 0, 0);
    apply_stimulus("sw_stall2", 4'd5, 0, 0);
    apply_stimulus("sw_memwr",  4'd5, 1, 0);

    bus.opcode = 6'b000010;
    apply_stimulus("j_fetch_stall", 4'd0, 0, 0);
    apply_stimulus("j_fetch",       4'd0, 1, 0);
    apply_stimulus("j_decode",      4'd1, 1, 0);
    apply_stimulus("j_jump",        4'd11, 1, 0);

    bus.opcode = 6'b001000;
    apply_stimulus("addi_fetch",  4'd0, 1, 0);
    apply_stimulus("addi_decode", 4'd1, 1, 0);
    apply_stimulus("addi_ex",     4'd9, 1, 0);
    apply_stimulus("addi_wb",     4'd10, 1, 0);

    bus.opcode = 6'b111111;
    apply_stimulus("ill_fetch",  4'd0, 1, 0);
    apply_stimulus("ill_decode", 4'd1, 1, 0);

    bus.opcode = 6'b101011;
    apply_stimulus("rst_sw_fetch",  4'd0, 1, 0);
    apply_stimulus("rst_sw_decode", 4'd1, 1, 0);
    apply_stimulus("rst_sw_memadr", 4'd2, 1, 0);
    apply_stimulus("rst_sw_stall",  4'd5, 0, 0);
    bus.mem_ready = 1'b0;
    #2;
    expected_q.push_back(spec_outputs(4'd5, 0, 0, bus.opcode));
    check_output("rst_sw_pre");
    reset = 1'b1;
    #1;
    expected_q.push_back('0);
    check_output("rst_async");
    @(posedge clk);
    #1;
    expected_q.push_back('0);
    check_output("rst_held");
    reset = 1'b0;
    apply_stimulus("rst_release_fetch",  4'd0, 1, 0);
    apply_stimulus("rst_release_decode", 4'd1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, addi and j. It is the producer of the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 sub, 10 use funct). It also drives every datapath enable and mux select, and stalls on a memory ready handshake.

## Interface
- No parameters. Opcodes, state codes and ALUOp codes are fixed constants.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high. State goes to FETCH immediately. All outputs read 0 while reset is high.
- opcode  input  6  instr[31:26] from the instruction register. Sampled only in DECODE and MEMADR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- alu_op  output  2  to the ALU control decoder.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write  output  1 each  datapath controls.
- pc_en  output  1  PC load, computed as pc_write | (branch & zero).
- illegal  output  1  high in DECODE when the opcode is unsupported.
- state  output  4  current state code, for debug.

## Operation
- Opcodes:
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - addi = 001000
  - j = 000010
- Any output not listed for a state is 0. State codes are 0 to 11 in the order below.
- **FETCH (0):** mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Goes to DECODE if mem_ready, otherwise stays in FETCH.
- **DECODE (1):** alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - lw or sw goes to MEMADR; R goes to EXEC; beq goes to BRANCH; addi goes to ADDIEX; j goes to JUMP.
  - Any other opcode: illegal=1, next state FETCH.
- **MEMADR (2):** alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD (3):** iord=1, mem_read=1. Goes to MEMWB when mem_ready, otherwise holds.
- **MEMWB (4):** reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- **MEMWR (5):** iord=1, mem_write=1, held for the whole wait. Goes to FETCH when mem_ready.
- **EXEC (6):** alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- **ALUWB (7):** reg_dst=1, mem_to_reg=0, reg_write=1. Goes to FETCH.
- **BRANCH (8):** alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 (internal). Goes to FETCH.
- **ADDIEX (9):** alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- **ADDIWB (10):** reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
- **JUMP (11):** pc_src=10, pc_write=1. Goes to FETCH.
- Unreachable state codes 12 to 15 go to FETCH on the next edge, with all outputs 0.

## Timing
- Outputs are combinational from the state register, except:
  - FETCH ir_write and pc_write, which depend on mem_ready;
  - pc_en, which depends on zero.
- Cycles per instruction with mem_ready tied high:
  - R = 4, lw = 5, sw = 4, addi = 4
  - beq = 3, j = 3
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No output changes during the stall.
- In BRANCH, pc_en = zero in the same cycle.
- At most one of mem_read and mem_write is high in any cycle. reg_write is never high in the same cycle as either of them.
- Reset asserted mid-instruction:
  - state = FETCH asynchronously;
  - no write enable may glitch high while reset is asserted;
  - the first cycle after release is FETCH.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants;
  - ALUOp codes 00/01/10, also used by the ALU control decoder;
  - the 4-bit state encodings;
  - alu_src_b and pc_src select codes.
- No sub-module. The block is one state register, a next-state case statement and an output-decode case statement.

## Test plan
- **Reset:** assert reset mid-MEMWR. Required: state=0 and mem_write=0 immediately. After release, the first cycle shows mem_read=1, alu_src_b=01.
- **R-type:** opcode 000000, mem_ready=1. Required state sequence 0, 1, 6, 7, 0. alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in ALUWB.
- **lw with a 2-cycle stall in MEMRD:** opcode 100011, mem_ready=0 for two cycles. Required sequence 0, 1, 2, 3, 3, 3, 4, 0. mem_to_reg=1 and reg_write=1 only in state 4.
- **beq:** opcode 000100 with zero=1. Required: pc_en=1, pc_src=01, alu_op=01 in state 8. Repeat with zero=0. Required: pc_en=0, and a 3-cycle instruction in both cases.
- **sw, j, addi:**
  - sw: mem_write held for the whole MEMWR stall.
  - j (000010): pc_src=10, pc_en=1 in state 11.
  - addi (001000): reg_write=1 and reg_dst=0 in state 10.
- **Illegal opcode:** opcode 111111. Required: illegal=1 in DECODE, no write enable asserted, next state 0.
